// File: rtl/crc_code_encoder_if.sv
// Handshake bundle between a data source, the CRC-4 encoder and its consumer.
// With CRC_ERR_INJECT_EN defined the bundle also carries err_mask, which
// flips codeword bits for decoder fault-injection tests.
interface crc_code_encoder_if;
    logic [7:0]  data_in;
    logic        data_valid_in;
    logic        data_ready_out;
    logic [11:0] encoded_data;
    logic        code_valid;
    logic        code_ready;
    logic        busy;
`ifdef CRC_ERR_INJECT_EN
    logic [11:0] err_mask;
`endif

    // Encoder side: consumes data words, produces codewords.
    modport slave (
        input  data_in,
        input  data_valid_in,
        output data_ready_out,
        output encoded_data,
        output code_valid,
        input  code_ready,
`ifdef CRC_ERR_INJECT_EN
        input  err_mask,
`endif
        output busy
    );

    // Environment side: supplies data words, accepts codewords.
    modport master (
        output data_in,
        output data_valid_in,
        input  data_ready_out,
        input  encoded_data,
        input  code_valid,
        output code_ready,
`ifdef CRC_ERR_INJECT_EN
        output err_mask,
`endif
        input  busy
    );
endinterface

// File: rtl/crc_code_encoder.sv
// Serial CRC-4 encoder, polynomial x^4+x+1.
// Accepts an 8-bit word, shifts {data, 4'b0000} MSB-first through an LFSR one
// bit per cycle (12 cycles) and presents the codeword {data, crc} until the
// consumer takes it. The resulting codeword divides to a zero remainder.
// Optional feature: define CRC_ERR_INJECT_EN to XOR bus.err_mask into the
// codeword as it is loaded (sampled only on the SHIFT->DONE edge).
module crc_code_encoder #(
    parameter logic [3:0] POLY = 4'b0011
) (
    input  logic             clk,
    input  logic             rst,
    crc_code_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] LAST_BIT = 4'd11;

    state_e      state_q,   state_d;
    logic [3:0]  lfsr_q,    lfsr_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [11:0] shreg_q,   shreg_d;
    logic [7:0]  hold_q,    hold_d;
    logic [11:0] enc_q,     enc_d;
    logic        cvalid_q,  cvalid_d;

    logic [3:0]  lfsr_step;
    logic [11:0] codeword;

    // LFSR advance by one message bit: shift, fold r[3] back through the taps,
    // and inject the next message bit at the bottom.
    always_comb begin
        lfsr_step = {lfsr_q[2:0], 1'b0}
                  ^ (lfsr_q[3] ? POLY : 4'b0000)
                  ^ {3'b000, shreg_q[11]};
`ifdef CRC_ERR_INJECT_EN
        codeword  = {hold_q, lfsr_step} ^ bus.err_mask;
`else
        codeword  = {hold_q, lfsr_step};
`endif
    end

    // Next-state and datapath decisions for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case can
        // leave a variable unassigned and infer a latch.
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        hold_d   = hold_q;
        enc_d    = enc_q;
        cvalid_d = cvalid_q;

        case (state_q)
            IDLE: begin
                if (bus.data_valid_in) begin
                    hold_d  = bus.data_in;
                    shreg_d = {bus.data_in, 4'b0000};
                    lfsr_d  = 4'b0000;
                    cnt_d   = 4'd0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                lfsr_d  = lfsr_step;
                shreg_d = {shreg_q[10:0], 1'b0};
                if (cnt_q == LAST_BIT) begin
                    // Twelfth bit: the final remainder is lfsr_step, so the
                    // codeword is loaded on this same edge.
                    cnt_d    = 4'd0;
                    enc_d    = codeword;
                    cvalid_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            DONE: begin
                // Returning to IDLE only; a new word waits for the next edge.
                if (bus.code_ready) begin
                    cvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                cvalid_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; a reset mid-word discards it.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: all registers here are a few bits wide, so every one is
            // reset; the observable encoded_data=0 after reset depends on it.
            state_q  <= IDLE;
            lfsr_q   <= 4'b0000;
            cnt_q    <= 4'd0;
            shreg_q  <= 12'h000;
            hold_q   <= 8'h00;
            enc_q    <= 12'h000;
            cvalid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from the values present before the edge.
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            hold_q   <= hold_d;
            enc_q    <= enc_d;
            cvalid_q <= cvalid_d;
        end
    end

    // Ready and busy are decoded straight from the state register.
    assign bus.data_ready_out = (state_q == IDLE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.encoded_data   = enc_q;
    assign bus.code_valid     = cvalid_q;

endmodule

// File: tb/tb_crc_code_encoder.sv
// Self-checking bench for crc_code_encoder. The reference model is plain
// modulo-2 long division by x^4+x+1; a codeword is "decoded" by checking its
// remainder is zero and its upper byte matches the word sent.
module tb_crc_code_encoder;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    crc_code_encoder_if bus ();

    crc_code_encoder #(.POLY(4'b0011)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of a 12-bit polynomial divided by x^4+x+1 (binary 10011).
    function automatic logic [3:0] crc_rem(input logic [11:0] word);
        logic [11:0] r;
        r = word;
        for (int i = 11; i >= 4; i--) begin
            if (r[i]) r = r ^ (12'b1_0011 << (i - 4));
        end
        return r[3:0];
    endfunction

    function automatic logic [11:0] model_code(input logic [7:0] d);
        return {d, crc_rem({d, 4'b0000})};
    endfunction

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        while (!bus.data_ready_out && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (!bus.data_ready_out) begin
            errors++;
            $display("FAIL send_ready: data_ready_out=%0b after %0d cycles, required 1", bus.data_ready_out, n);
        end
        bus.data_in       = d;
        bus.data_valid_in = 1'b1;
        step();
        bus.data_valid_in = 1'b0;
    endtask

    // Count edges until code_valid rises (bounded by limit).
    task automatic wait_valid(output int n, input int limit);
        n = 0;
        while (!bus.code_valid && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        bit seen;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (bus.code_valid !== 1'b0 || bus.data_ready_out !== 1'b1 ||
            bus.busy !== 1'b0 || bus.encoded_data !== 12'h000) begin
            errors++;
            $display("FAIL reset_init: cv=%0b rdy=%0b busy=%0b enc=%03h, required 0 1 0 000",
                     bus.code_valid, bus.data_ready_out, bus.busy, bus.encoded_data);
        end
        // Abort a word mid-SHIFT.
        bus.code_ready = 1'b1;
        send(8'hA5);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_shift: busy=%0b, required 1", bus.busy);
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (bus.code_valid !== 1'b0 || bus.data_ready_out !== 1'b1 ||
            bus.busy !== 1'b0 || bus.encoded_data !== 12'h000) begin
            errors++;
            $display("FAIL reset_midshift: cv=%0b rdy=%0b busy=%0b enc=%03h, required 0 1 0 000",
                     bus.code_valid, bus.data_ready_out, bus.busy, bus.encoded_data);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.code_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_code: aborted word presented code_valid=1, required never");
        end
        n = 0;
    endtask

    task automatic test_single();
        int n;
        bus.code_ready = 1'b1;
        send(8'hA5);
        wait_valid(n, 30);
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL single_latency: code_valid after %0d edges, required 12", n);
        end
        checks++;
        if (bus.encoded_data !== 12'hA5B || model_code(8'hA5) !== 12'hA5B) begin
            errors++;
            $display("FAIL single_code: enc=%03h model=%03h, required A5B", bus.encoded_data, model_code(8'hA5));
        end
        step();
        checks++;
        if (bus.code_valid !== 1'b0 || bus.data_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse: cv=%0b rdy=%0b one edge later, required 0 1", bus.code_valid, bus.data_ready_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vec [3];
        logic [11:0] known [3];
        int acc_cyc [3];
        int in_idx, out_idx, cyc;
        bit accept;
        vec   = '{8'h00, 8'h01, 8'hFF};
        known = '{12'h000, 12'h013, 12'hFF4};
        in_idx = 0;
        out_idx = 0;
        cyc = 0;
        bus.code_ready    = 1'b1;
        bus.data_in       = vec[0];
        bus.data_valid_in = 1'b1;
        while (out_idx < 3 && cyc < 80) begin
            accept = bus.data_ready_out && bus.data_valid_in;
            step();
            cyc++;
            if (accept) begin
                acc_cyc[in_idx] = cyc;
                in_idx++;
                if (in_idx < 3) bus.data_in = vec[in_idx];
                else            bus.data_valid_in = 1'b0;
            end
            if (bus.code_valid) begin
                checks++;
                if (bus.encoded_data !== known[out_idx] || model_code(vec[out_idx]) !== known[out_idx]) begin
                    errors++;
                    $display("FAIL b2b_code[%0d]: enc=%03h model=%03h, required %03h",
                             out_idx, bus.encoded_data, model_code(vec[out_idx]), known[out_idx]);
                end
                out_idx++;
            end
        end
        bus.data_valid_in = 1'b0;
        checks++;
        if (out_idx != 3 || in_idx != 3) begin
            errors++;
            $display("FAIL b2b_count: accepted=%0d emitted=%0d, required 3 3", in_idx, out_idx);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != 14) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d]: %0d cycles, required 14", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        bus.code_ready = 1'b0;
        send(8'hA5);
        wait_valid(n, 30);
        checks++;
        if (!bus.code_valid) begin
            errors++;
            $display("FAIL bp_valid: code_valid=0 after %0d edges, required 1", n);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.data_in       = 8'($urandom);
            bus.data_valid_in = 1'($urandom_range(0, 1));
            step();
            if (bus.code_valid !== 1'b1 || bus.encoded_data !== 12'hA5B ||
                bus.data_ready_out !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        bus.data_valid_in = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d of 20 cycles lost cv=1/enc=A5B/rdy=0, last enc=%03h", bad, bus.encoded_data);
        end
        bus.code_ready = 1'b1;
        step();
        checks++;
        if (bus.code_valid !== 1'b0 || bus.data_ready_out !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: cv=%0b rdy=%0b busy=%0b, required 0 1 0",
                     bus.code_valid, bus.data_ready_out, bus.busy);
        end
    endtask

    // Every byte through the encoder, with random consumer stalls; each
    // codeword must decode to a zero remainder and return the byte sent.
    task automatic test_loopback();
        int n;
        int bad_crc, bad_data, bad_to;
        logic [11:0] cw;
        bad_crc = 0;
        bad_data = 0;
        bad_to = 0;
        for (int d = 0; d < 256; d++) begin
            bus.code_ready = 1'b0;
            send(8'(d));
            wait_valid(n, 30);
            if (!bus.code_valid) bad_to++;
            for (int s = $urandom_range(0, 2); s > 0; s--) step();
            cw = bus.encoded_data;
            if (crc_rem(cw) !== 4'h0 || cw !== model_code(8'(d))) bad_crc++;
            if (cw[11:4] !== 8'(d)) bad_data++;
            bus.code_ready = 1'b1;
            step();
        end
        checks++;
        if (bad_to != 0) begin
            errors++;
            $display("FAIL loop_timeout: %0d words never presented, required 0", bad_to);
        end
        checks++;
        if (bad_crc != 0) begin
            errors++;
            $display("FAIL loop_crc: %0d codewords with decoder error, required 0", bad_crc);
        end
        checks++;
        if (bad_data != 0) begin
            errors++;
            $display("FAIL loop_data: %0d decoded bytes differ from input, required 0", bad_data);
        end
    endtask

`ifdef CRC_ERR_INJECT_EN
    task automatic test_err_inject();
        int n;
        bus.code_ready = 1'b1;
        bus.err_mask   = 12'h001;
        send(8'hA5);
        bus.err_mask   = 12'h000;  // ignored mid-SHIFT; sampled only on the last edge
        for (int i = 0; i < 10; i++) step();
        bus.err_mask   = 12'h001;
        wait_valid(n, 30);
        checks++;
        if (bus.encoded_data !== 12'hA5A) begin
            errors++;
            $display("FAIL inject_code: enc=%03h, required A5A", bus.encoded_data);
        end
        checks++;
        if (crc_rem(bus.encoded_data) === 4'h0) begin
            errors++;
            $display("FAIL inject_detect: remainder=0 for enc=%03h, required nonzero", bus.encoded_data);
        end
        step();
        bus.err_mask = 12'h000;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst               = 1'b1;
        bus.data_in       = 8'h00;
        bus.data_valid_in = 1'b0;
        bus.code_ready    = 1'b0;
`ifdef CRC_ERR_INJECT_EN
        bus.err_mask      = 12'h000;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_loopback();
`ifdef CRC_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc_code_encoder.md
Name: crc_code_encoder

Overview:
- Serial CRC-4 encoder, polynomial x^4+x+1. Sits directly upstream of the CRC decoder.
- Accepts an 8-bit data word over a valid/ready handshake and shifts {data, 4'b0000} MSB-first through an LFSR, one bit per cycle.
- Emits a 12-bit codeword {data[7:0], crc[3:0]} over a second valid/ready handshake. This is exactly the format the decoder loads and checks to a zero remainder.

Parameters:
- POLY, 4'b0011, low-order feedback taps of x^4+x+1 (bit i set means XOR r[3] into new bit i).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- data_in  input  8  data word to encode
- data_valid_in  input  1  data_in is valid
- data_ready_out  output  1  encoder can accept a word
- encoded_data  output  12  codeword {data, crc}
- code_valid  output  1  encoded_data is valid
- code_ready  input  1  downstream accepts the codeword
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset: one clock and reset. rst is synchronous and active-high; rst sampled high at a clk edge forces the following:
  - state=IDLE, lfsr=0, bit counter=0, shift register=0, data hold register=0
  - data_ready_out=1, code_valid=0, busy=0, encoded_data=12'h000
- rst mid-SHIFT or mid-DONE aborts the word; the codeword is never presented.
- IDLE:
  - data_ready_out=1.
  - On an edge with data_valid_in=1: capture data_in into the hold register; load the shift register with {data_in, 4'b0000}; clear lfsr and counter; go to SHIFT.
- SHIFT:
  - data_ready_out=0, busy=1.
  - Each cycle: b = shreg[11]; lfsr <= {lfsr[2:0],1'b0} ^ (lfsr[3] ? POLY : 0) ^ {3'b000, b}; shreg <= shreg<<1; counter++.
  - After exactly 12 shift cycles (counter reaches 11 and wraps), go to DONE.
  - encoded_data is loaded with {hold, next lfsr} on that same edge.
- DONE:
  - code_valid=1; encoded_data held stable until handshake completes.
  - On an edge with code_ready=1: code_valid falls; go to IDLE.
  - encoded_data keeps its last value; it is don't-care when code_valid=0.
- Latency: handshake accepted at edge N gives code_valid high after edge N+12. With code_ready tied high, throughput is one word per 14 cycles.
- Ignored inputs:
  - data_valid_in is ignored outside IDLE; no queueing.
  - code_ready is ignored when code_valid=0.
- Simultaneous accept/return: code_ready in DONE returns to IDLE only. The next word can be accepted no earlier than the following edge, because data_ready_out is combinational from state and is 0 in DONE.
- No arithmetic overflow. The counter is 4 bits and is compared against 11 explicitly; values 12-15 are unreachable.

Optional Feature:
- Macro CRC_ERR_INJECT_EN, for fault injection to exercise decoder error detection.
- Defined:
  - Adds input port err_mask[11:0].
  - On the SHIFT->DONE edge, encoded_data = {hold, crc} ^ err_mask.
  - err_mask is sampled only on that edge.
- Undefined: port absent; encoded_data is the clean codeword.

Test Plan:
- Reset: assert rst 2 cycles mid-SHIFT (data 0xA5). Required: code_valid=0, data_ready_out=1, busy=0, encoded_data=0x000, and no codeword is ever presented.
- Single word, code_ready=1: data 0xA5 -> encoded_data=0xA5B, code_valid high exactly 12 edges after the accept edge, for one cycle.
- Known vectors, back-to-back, code_ready=1: 0x00->0x000, 0x01->0x013, 0xFF->0xFF4. Each accept is 14 cycles after the previous one.
- Backpressure: data 0xA5 with code_ready=0 for 20 cycles. Required: code_valid stays 1, encoded_data stays 0xA5B, data_ready_out stays 0, and data_valid_in pulses during this window are ignored. Raising code_ready returns to IDLE.
- Loopback: encoder output into the CRC decoder for all 256 inputs. Required: decoder error flag=0 and decoded byte equals input.
- With CRC_ERR_INJECT_EN, data 0xA5, err_mask=0x001. Required: encoded_data=0xA5A; the decoder flags an error.
